// File: rtl/mecanismo_flipping_pipe.sv
// Registered bit-permutation stage with valid/ready handshake: pass, full reverse,
// group reverse, or alternating reverse per beat, behind a one-deep output register.
module mecanismo_flipping_pipe #(
  parameter int N     = 16,
  parameter int G     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [N-1:0]     in_data,
  input  logic [1:0]       in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             alt_phase
);

  if (N < 2 || G < 1 || (N % G) != 0) begin : g_bad_params
    $error("mecanismo_flipping_pipe: need N >= 2, G >= 1 and N %% G == 0");
  end

  logic [N-1:0]     rev_p0;
  logic [N-1:0]     grp_p0;
  logic [N-1:0]     perm_p0;
  logic [N-1:0]     data_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] cnt_q;
  logic             phase_q;
  logic             accept;
  logic             consume;

  // Stage p0: fixed wiring for the two reversal patterns, constant indices only
  for (genvar i = 0; i < N; i++) begin : g_perm
    assign rev_p0[i] = in_data[N-1-i];
    assign grp_p0[i] = in_data[(i / G) * G + (G - 1 - (i % G))];
  end

  function automatic logic [N-1:0] select_word(
    input logic [1:0]   mode,
    input logic         phase,
    input logic [N-1:0] pass_w,
    input logic [N-1:0] rev_w,
    input logic [N-1:0] grp_w
  );
    logic [N-1:0] r;
    unique case (mode)
      2'b00:   r = pass_w;
      2'b01:   r = rev_w;
      2'b10:   r = grp_w;
      default: r = phase ? rev_w : pass_w;
    endcase
    return r;
  endfunction

  assign perm_p0  = select_word(in_mode, phase_q, in_data, rev_p0, grp_p0);
  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = vld_p1 && out_ready;

  // Stage p1: output register; data only loads on accept so idle X inputs never reach it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      if (accept) begin
        data_p1 <= perm_p0;
        vld_p1  <= 1'b1;
      end else if (consume) begin
        vld_p1  <= 1'b0;
      end
      // clear overrides the bookkeeping of a same-cycle accept, not its data
      if (clear) begin
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else if (accept) begin
        cnt_q <= cnt_q + 1'b1;
        if (in_mode == 2'b11) phase_q <= ~phase_q;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;
  assign beat_cnt  = cnt_q;
  assign alt_phase = phase_q;

endmodule

// File: tb/tb_mecanismo_flipping_pipe.sv
// Directed table-driven bench for mecanismo_flipping_pipe (N=16, G=4, CNT_W=4)
// plus hand-written backpressure, clear, wrap and async reset sequences.
module tb_mecanismo_flipping_pipe;

  localparam int N     = 16;
  localparam int G     = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic [N-1:0]     in_data;
  logic [1:0]       in_mode;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] beat_cnt;
  logic             alt_phase;

  mecanismo_flipping_pipe #(.N(N), .G(G), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .beat_cnt  (beat_cnt),
    .alt_phase (alt_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  m;
    logic [15:0] exp_out;
    logic        exp_ph;
  } vec_t;

  vec_t tbl[9];
  int   n_tests;
  int   n_fail;
  int   exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_cnt = 0;

    tbl[0] = '{16'h1234, 2'b00, 16'h1234, 1'b0};
    tbl[1] = '{16'h1234, 2'b01, 16'h2C48, 1'b0};
    tbl[2] = '{16'h1234, 2'b10, 16'h84C2, 1'b0};
    tbl[3] = '{16'h0001, 2'b01, 16'h8000, 1'b0};
    tbl[4] = '{16'h0001, 2'b11, 16'h0001, 1'b1};
    tbl[5] = '{16'h0001, 2'b11, 16'h8000, 1'b0};
    tbl[6] = '{16'h0001, 2'b11, 16'h0001, 1'b1};
    tbl[7] = '{16'h0001, 2'b00, 16'h0001, 1'b1};
    tbl[8] = '{16'h0001, 2'b11, 16'h8000, 1'b0};

    rst_n     = 1'b0;
    clear     = 1'b0;
    in_data   = '0;
    in_mode   = 2'b00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data",  32'(out_data),  32'd0);
    chk("reset_beat_cnt",  32'(beat_cnt),  32'd0);
    chk("reset_alt_phase", 32'(alt_phase), 32'd0);
    chk("reset_in_ready",  32'(in_ready),  32'd1);

    // Mode and alternating table, one beat per cycle
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = tbl[i].d;
      in_mode  = tbl[i].m;
      step();
      exp_cnt = (exp_cnt + 1) % 16;
      chk($sformatf("tbl%0d_out_data", i),  32'(out_data),  32'(tbl[i].exp_out));
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("tbl%0d_alt_phase", i), 32'(alt_phase), 32'(tbl[i].exp_ph));
      chk($sformatf("tbl%0d_beat_cnt", i),  32'(beat_cnt),  32'(exp_cnt));
      if (i == 3) chk("modes_beat_cnt4", 32'(beat_cnt), 32'd4);
    end
    in_valid = 1'b0;
    in_data  = 'x;
    in_mode  = 'x;
    step();
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_out_data",  32'(out_data),  32'h8000);
    chk("drain_beat_cnt",  32'(beat_cnt),  32'(exp_cnt));

    // Backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00F0;
    in_mode   = 2'b00;
    step();
    exp_cnt = (exp_cnt + 1) % 16;
    chk("bp_first_out", 32'(out_data), 32'h00F0);
    in_data = 16'h000F;
    in_mode = 2'b01;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_in_ready%0d", c), 32'(in_ready), 32'd0);
      step();
      chk($sformatf("bp_hold_data%0d", c),  32'(out_data),  32'h00F0);
      chk($sformatf("bp_hold_valid%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold_cnt%0d", c),   32'(beat_cnt),  32'(exp_cnt));
      in_mode = (c == 1) ? 2'b10 : 2'b01;
    end
    in_mode   = 2'b01;
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    step();
    exp_cnt = (exp_cnt + 1) % 16;
    chk("bp_b2b0_data",  32'(out_data),  32'hF000);
    chk("bp_b2b0_valid", 32'(out_valid), 32'd1);
    in_data = 16'h1234;
    in_mode = 2'b10;
    step();
    exp_cnt = (exp_cnt + 1) % 16;
    chk("bp_b2b1_data",  32'(out_data),  32'h84C2);
    chk("bp_b2b1_valid", 32'(out_valid), 32'd1);
    in_data = 16'h0003;
    in_mode = 2'b01;
    step();
    exp_cnt = (exp_cnt + 1) % 16;
    chk("bp_b2b2_data",  32'(out_data),  32'hC000);
    chk("bp_b2b2_valid", 32'(out_valid), 32'd1);
    chk("bp_beat_cnt",   32'(beat_cnt),  32'(exp_cnt));
    in_valid = 1'b0;
    step();
    chk("bp_drain_valid", 32'(out_valid), 32'd0);

    // Clear colliding with a mode-11 accept at alt_phase=1
    in_valid = 1'b1;
    in_data  = 16'h0001;
    in_mode  = 2'b11;
    step();
    chk("clr_pre_out",   32'(out_data),  32'h0001);
    chk("clr_pre_phase", 32'(alt_phase), 32'd1);
    clear = 1'b1;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_data",  32'(out_data),  32'h8000);
    chk("clr_out_valid", 32'(out_valid), 32'd1);
    chk("clr_beat_cnt",  32'(beat_cnt),  32'd0);
    chk("clr_alt_phase", 32'(alt_phase), 32'd0);
    step();

    // Counter wrap: 17 beats into a 4-bit counter
    in_valid = 1'b1;
    in_mode  = 2'b00;
    for (int k = 0; k < 17; k++) begin
      in_data = 16'(k);
      step();
    end
    in_valid = 1'b0;
    chk("wrap_beat_cnt", 32'(beat_cnt), 32'd1);
    chk("wrap_last_out", 32'(out_data), 32'h0010);
    step();

    // Asynchronous reset with a pending word
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0001;
    in_mode   = 2'b11;
    step();
    in_valid = 1'b0;
    chk("arst_pre_valid", 32'(out_valid), 32'd1);
    chk("arst_pre_phase", 32'(alt_phase), 32'd1);
    chk("arst_pre_cnt",   32'(beat_cnt),  32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data",  32'(out_data),  32'd0);
    chk("arst_beat_cnt",  32'(beat_cnt),  32'd0);
    chk("arst_alt_phase", 32'(alt_phase), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_in_ready",   32'(in_ready),  32'd1);
    chk("arst_post_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
